// File: rtl/seq_det_pkg.sv
// Shared constants and helpers for the programmable serial pattern detector.
package seq_det_pkg;

  localparam int unsigned DEF_MAX_LEN   = 32'd8;
  localparam logic [7:0]  DEF_RST_PAT   = 8'b0000_1010;
  localparam int unsigned DEF_RST_LEN   = 32'd4;
  localparam logic        DEF_RST_OVLAP = 1'b1;
  localparam int unsigned MASK_W        = 32'd64;

  function automatic int len_w(input int unsigned max_len);
    return $clog2(max_len + 32'd1);
  endfunction

  // Mask with the low `len` bits set; callers truncate to their pattern width.
  function automatic logic [MASK_W-1:0] len_mask(input int unsigned len);
    logic [MASK_W-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < MASK_W; i++) begin
      m[i] = (i < len);
    end
    return m;
  endfunction

endpackage

// File: rtl/seq_det_cmp.sv
// Masked compare of the receive window against the programmed pattern.
module seq_det_cmp
  import seq_det_pkg::*;
#(
  parameter int unsigned MAX_LEN = DEF_MAX_LEN,
  parameter int unsigned LEN_W   = len_w(MAX_LEN)
) (
  input  logic [MAX_LEN-1:0] win,
  input  logic [MAX_LEN-1:0] pat,
  input  logic [LEN_W-1:0]   len,
  output logic               hit
);

  logic [MAX_LEN-1:0] mask_s;

  assign mask_s = MAX_LEN'(len_mask(32'(len)));
  assign hit    = ((win ^ pat) & mask_s) == '0;

endmodule

// File: rtl/seq_det_prog.sv
// Runtime-programmable serial pattern detector with Mealy match output.
// Optional saturating match counter enabled by defining SEQ_DET_MATCH_CNT_EN.
module seq_det_prog
  import seq_det_pkg::*;
#(
  parameter int unsigned        MAX_LEN   = DEF_MAX_LEN,
  parameter int unsigned        LEN_W     = len_w(MAX_LEN),
  parameter logic [MAX_LEN-1:0] RST_PAT   = MAX_LEN'(DEF_RST_PAT),
  parameter int unsigned        RST_LEN   = DEF_RST_LEN,
  parameter logic               RST_OVLAP = DEF_RST_OVLAP
`ifdef SEQ_DET_MATCH_CNT_EN
  , parameter int unsigned      CNT_W     = 32'd16
`endif
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               d,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_ovlap,
`ifdef SEQ_DET_MATCH_CNT_EN
  output logic [CNT_W-1:0]   match_cnt,
`endif
  output logic               q,
  output logic               cfg_err
);

  // The oldest history bit never reaches a window, so only MAX_LEN-1 bits are kept.
  logic [MAX_LEN-2:0] hist_q, hist_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic               ovlap_q, ovlap_d;
  logic               cfg_err_q, cfg_err_d;
  logic [MAX_LEN-1:0] win_s;
  logic               hit_s, fill_ok_s, q_s, len_bad_s;

  assign win_s = {hist_q, d};

  seq_det_cmp #(
    .MAX_LEN(MAX_LEN),
    .LEN_W  (LEN_W)
  ) u_cmp (
    .win(win_s),
    .pat(pat_q),
    .len(len_q),
    .hit(hit_s)
  );

  // fill >= len-1, evaluated one bit wider so len=0 cannot wrap.
  assign fill_ok_s = ({1'b0, fill_q} + (LEN_W+1)'(1)) >= {1'b0, len_q};
  assign q_s       = en & ~cfg_load & ~cfg_err_q & ~reset & fill_ok_s & hit_s;
  assign len_bad_s = (cfg_len == '0) | ({1'b0, cfg_len} > (LEN_W+1)'(MAX_LEN));

  assign q       = q_s;
  assign cfg_err = cfg_err_q;

  always_comb begin
    hist_d    = hist_q;
    fill_d    = fill_q;
    len_d     = len_q;
    pat_d     = pat_q;
    ovlap_d   = ovlap_q;
    cfg_err_d = cfg_err_q;
    if (cfg_load) begin
      pat_d     = cfg_pattern;
      len_d     = cfg_len;
      ovlap_d   = cfg_ovlap;
      fill_d    = '0;
      cfg_err_d = len_bad_s;
    end else if (en) begin
      hist_d = win_s[MAX_LEN-2:0];
      if (q_s && !ovlap_q) begin
        fill_d = '0;
      end else if (fill_q == LEN_W'(MAX_LEN)) begin
        fill_d = fill_q;
      end else begin
        fill_d = fill_q + LEN_W'(1);
      end
    end else begin
      hist_d = hist_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist_q    <= '0;
      fill_q    <= '0;
      len_q     <= LEN_W'(RST_LEN);
      pat_q     <= RST_PAT;
      ovlap_q   <= RST_OVLAP;
      cfg_err_q <= 1'b0;
    end else begin
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      len_q     <= len_d;
      pat_q     <= pat_d;
      ovlap_q   <= ovlap_d;
      cfg_err_q <= cfg_err_d;
    end
  end

`ifdef SEQ_DET_MATCH_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (cfg_load) begin
      cnt_d = '0;
    end else if (q_s && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign match_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_seq_det_prog.sv
// Self-checking bench for seq_det_prog: directed scenarios plus randomized
// traffic against a queue-based model of recently received fresh bits.
module tb_seq_det_prog;

  localparam int MAX_LEN = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0;
  logic       d = 1'b0;
  logic       cfg_load = 1'b0;
  logic [7:0] cfg_pattern = 8'h00;
  logic [3:0] cfg_len = 4'd0;
  logic       cfg_ovlap = 1'b0;
  logic       q, cfg_err;

  int checks = 0;
  int errors = 0;

  logic [7:0] m_pat;
  int         m_len;
  logic       m_ovlap, m_err;
  logic       mq[$];

  always #5 clk = ~clk;

`ifdef SEQ_DET_MATCH_CNT_EN
  logic [1:0] match_cnt;
  seq_det_prog #(.CNT_W(2)) dut (
    .clk(clk), .reset(reset), .en(en), .d(d), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_ovlap(cfg_ovlap),
    .match_cnt(match_cnt), .q(q), .cfg_err(cfg_err)
  );
`else
  seq_det_prog dut (
    .clk(clk), .reset(reset), .en(en), .d(d), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_ovlap(cfg_ovlap),
    .q(q), .cfg_err(cfg_err)
  );
`endif

  task automatic model_reset();
    m_pat   = 8'b0000_1010;
    m_len   = 4;
    m_ovlap = 1'b1;
    m_err   = 1'b0;
    mq.delete();
  endtask

  // Match when the last len bits (oldest first) spell the pattern, all received since the last clear.
  function automatic logic model_q(input logic e, input logic dd, input logic ld);
    logic s[$];
    int   n;
    if (!e || ld || m_err) return 1'b0;
    if (mq.size() + 1 < m_len) return 1'b0;
    s = mq;
    s.push_back(dd);
    n = s.size();
    for (int i = 0; i < m_len; i++) begin
      if (s[n-1-i] !== m_pat[i]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic drive(input logic e, input logic dd, input logic ld, input logic [7:0] p,
                       input int l, input logic o, output logic q_obs, output logic q_exp,
                       output logic err_obs, output logic err_exp);
    @(negedge clk);
    en = e; d = dd; cfg_load = ld; cfg_pattern = p; cfg_len = 4'(l); cfg_ovlap = o;
    #1;
    q_obs = q;
    q_exp = model_q(e, dd, ld);
    @(posedge clk);
    if (ld) begin
      m_pat = p; m_len = l & 15; m_ovlap = o;
      m_err = (m_len == 0) || (m_len > MAX_LEN);
      mq.delete();
    end else if (e) begin
      mq.push_back(dd);
      if (q_exp && !m_ovlap) mq.delete();
      if (mq.size() > MAX_LEN) void'(mq.pop_front());
    end
    #1;
    err_obs = cfg_err;
    err_exp = m_err;
    cfg_load = 1'b0;
  endtask

  task automatic send(input logic e, input logic dd, output logic qo, output logic qe,
                      output logic eo, output logic ee);
    drive(e, dd, 1'b0, 8'h00, 0, 1'b0, qo, qe, eo, ee);
  endtask

  task automatic load_cfg(input logic [7:0] p, input int l, input logic o, output logic qo,
                          output logic qe, output logic eo, output logic ee);
    drive(1'($urandom), 1'($urandom), 1'b1, p, l, o, qo, qe, eo, ee);
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1; en = 1'b1; d = 1'b0; cfg_load = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (q !== 1'b0) begin errors++; $display("FAIL reset_q got %b want 0", q); end
    checks++;
    if (cfg_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", cfg_err); end
    @(negedge clk);
    en = 1'b0;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_default_overlap();
    logic [5:0] bits = 6'b101010;
    logic [5:0] exp  = 6'b000101;
    logic qo, qe, eo, ee;
    for (int i = 0; i < 6; i++) begin
      send(1'b1, bits[5-i], qo, qe, eo, ee);
      checks++;
      if (qo !== exp[5-i]) begin errors++; $display("FAIL dflt_q bit%0d got %b want %b", i+1, qo, exp[5-i]); end
    end
    checks++;
    if (eo !== 1'b0) begin errors++; $display("FAIL dflt_err got %b want 0", eo); end
  endtask

  task automatic test_non_overlap();
    logic [7:0] bits = 8'b10101010;
    logic [7:0] exp  = 8'b00010001;
    logic qo, qe, eo, ee;
    load_cfg(8'b0000_1010, 4, 1'b0, qo, qe, eo, ee);
    checks++;
    if (qo !== 1'b0) begin errors++; $display("FAIL novl_load_q got %b want 0", qo); end
    for (int i = 0; i < 8; i++) begin
      send(1'b1, bits[7-i], qo, qe, eo, ee);
      checks++;
      if (qo !== exp[7-i]) begin errors++; $display("FAIL novl_q bit%0d got %b want %b", i+1, qo, exp[7-i]); end
    end
  endtask

  task automatic test_en_gaps();
    logic [10:0] en_t = 11'b11111001111;
    logic [10:0] d_t  = 11'b11110000101;
    logic [10:0] exp  = 11'b00000000001;
    logic qo, qe, eo, ee, dd;
    load_cfg(8'b1110_0101, 8, 1'b1, qo, qe, eo, ee);
    for (int i = 0; i < 11; i++) begin
      dd = en_t[10-i] ? d_t[10-i] : 1'($urandom);
      send(en_t[10-i], dd, qo, qe, eo, ee);
      checks++;
      if (qo !== exp[10-i]) begin errors++; $display("FAIL gaps_q step%0d got %b want %b", i, qo, exp[10-i]); end
    end
  endtask

  task automatic test_cfg_err();
    logic qo, qe, eo, ee;
    load_cfg(8'h00, 0, 1'b1, qo, qe, eo, ee);
    checks++;
    if (eo !== 1'b1) begin errors++; $display("FAIL err_set got %b want 1", eo); end
    for (int i = 0; i < 16; i++) begin
      send(1'b1, 1'($urandom), qo, qe, eo, ee);
      checks++;
      if (qo !== 1'b0) begin errors++; $display("FAIL err_q step%0d got %b want 0", i, qo); end
    end
    load_cfg(8'b0000_0011, 2, 1'b1, qo, qe, eo, ee);
    checks++;
    if (eo !== 1'b0) begin errors++; $display("FAIL err_clear got %b want 0", eo); end
    for (int i = 0; i < 3; i++) begin
      send(1'b1, 1'b1, qo, qe, eo, ee);
      checks++;
      if (qo !== (i != 0)) begin errors++; $display("FAIL len2_q bit%0d got %b want %b", i+1, qo, i != 0); end
    end
  endtask

  task automatic test_len1();
    logic qo, qe, eo, ee, e, dd;
    load_cfg(8'b0000_0001, 1, 1'b1, qo, qe, eo, ee);
    for (int i = 0; i < 12; i++) begin
      e = 1'($urandom); dd = 1'($urandom);
      send(e, dd, qo, qe, eo, ee);
      checks++;
      if (qo !== (e & dd)) begin errors++; $display("FAIL len1_q step%0d got %b want %b", i, qo, e & dd); end
    end
  endtask

  task automatic test_reset_mid();
    logic [4:0] bits = 5'b01010;
    logic [4:0] exp  = 5'b00001;
    logic qo, qe, eo, ee;
    test_reset();
    send(1'b1, 1'b1, qo, qe, eo, ee);
    send(1'b1, 1'b0, qo, qe, eo, ee);
    send(1'b1, 1'b1, qo, qe, eo, ee);
    @(negedge clk);
    en = 1'b1; d = 1'b0; cfg_load = 1'b0;
    #1;
    checks++;
    if (q !== 1'b1) begin errors++; $display("FAIL mid_pre_q got %b want 1", q); end
    #1 reset = 1'b1;
    #1;
    checks++;
    if (q !== 1'b0) begin errors++; $display("FAIL mid_rst_q got %b want 0", q); end
    en = 1'b0;
    #1 reset = 1'b0;
    model_reset();
    for (int i = 0; i < 5; i++) begin
      send(1'b1, bits[4-i], qo, qe, eo, ee);
      checks++;
      if (qo !== exp[4-i]) begin errors++; $display("FAIL mid_post_q bit%0d got %b want %b", i+1, qo, exp[4-i]); end
    end
  endtask

  task automatic test_random();
    logic qo, qe, eo, ee;
    int   l;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        case ($urandom_range(0, 5))
          0:       l = 0;
          1:       l = $urandom_range(9, 15);
          2, 3:    l = $urandom_range(1, 3);
          default: l = $urandom_range(1, 8);
        endcase
        load_cfg(8'($urandom), l, 1'($urandom), qo, qe, eo, ee);
      end else begin
        send(($urandom_range(0, 3) != 0), 1'($urandom), qo, qe, eo, ee);
      end
      checks++;
      if (qo !== qe) begin errors++; $display("FAIL rand_q step%0d got %b want %b", i, qo, qe); end
      checks++;
      if (eo !== ee) begin errors++; $display("FAIL rand_err step%0d got %b want %b", i, eo, ee); end
    end
  endtask

`ifdef SEQ_DET_MATCH_CNT_EN
  task automatic test_match_cnt();
    logic [1:0] exp_cnt[5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    logic qo, qe, eo, ee;
    test_reset();
    load_cfg(8'b0000_0001, 1, 1'b1, qo, qe, eo, ee);
    for (int i = 0; i < 5; i++) begin
      send(1'b1, 1'b1, qo, qe, eo, ee);
      checks++;
      if (match_cnt !== exp_cnt[i]) begin errors++; $display("FAIL cnt step%0d got %0d want %0d", i, match_cnt, exp_cnt[i]); end
    end
    load_cfg(8'b0000_0001, 1, 1'b1, qo, qe, eo, ee);
    checks++;
    if (match_cnt !== 2'd0) begin errors++; $display("FAIL cnt_clear got %0d want 0", match_cnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_default_overlap();
    test_non_overlap();
    test_en_gaps();
    test_cfg_err();
    test_len1();
    test_reset_mid();
    test_random();
`ifdef SEQ_DET_MATCH_CNT_EN
    test_match_cnt();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_det_prog.md
Name: seq_det_prog

Overview:
- Runtime-programmable serial pattern detector. Generalises the fixed 4-bit "1010" Mealy detector.
- Pattern length is parametrised up to MAX_LEN bits, and the pattern is loadable at run time.
- Overlap vs non-overlap mode is selectable per configuration.
- Input bits are qualified by an enable; output is a Mealy match pulse.
- Sits on a serial bit stream in front of framing/sync logic; out of reset it behaves as an overlapping 1010 detector.

Parameters:
- MAX_LEN, 8, maximum pattern length in bits (>=2).
- LEN_W, $clog2(MAX_LEN+1), width of length field.
- RST_PAT, 8'b0000_1010, pattern in force after reset (right-aligned).
- RST_LEN, 4, length in force after reset.
- RST_OVLAP, 1, overlap mode in force after reset.
- CNT_W, 16, match counter width (used only with the optional feature).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- en  in  1  d is a valid serial bit this cycle.
- d  in  1  serial data bit.
- cfg_load  in  1  load cfg_* this cycle.
- cfg_pattern  in  MAX_LEN  new pattern, right-aligned; bit [len-1] is the first bit received, bit [0] the last.
- cfg_len  in  LEN_W  new pattern length.
- cfg_ovlap  in  1  1 = overlapping, 0 = non-overlapping.
- q  out  1  Mealy match pulse, combinational from state and d.
- cfg_err  out  1  registered; last load had an illegal length.
- match_cnt  out  CNT_W  saturating match count (MATCH_CNT_EN only).

Behaviour:
- Reset is one clock and asynchronous, active-high.
- On reset:
  - hist = 0, fill = 0, cfg_err = 0.
  - pat = RST_PAT, len = RST_LEN, ovlap = RST_OVLAP.
  - q = 0 while reset is high.
- State:
  - hist[MAX_LEN-1:0] holds the last received bits, LSB newest.
  - fill (0..MAX_LEN, saturating) counts valid history bits.
- Window: win = {hist[MAX_LEN-2:0], d}.
- Match condition: q = en & ~cfg_load & ~cfg_err & (fill >= len-1) & (win[len-1:0] == pat[len-1:0]). Bits above len are ignored.
- Output is same-cycle, zero latency, one pulse per matching bit.
- On en=1 (no load):
  - hist <= {hist[MAX_LEN-2:0], d}.
  - fill <= min(fill+1, MAX_LEN).
- Mode on a match:
  - Overlap mode: fill keeps counting.
  - Non-overlap mode: fill <= 0, so the next match needs len fresh bits.
- en=0: hist and fill hold, q=0. Gaps in en do not break a partial match.
- cfg_load=1 (takes priority over en):
  - Registers pattern, length and mode; fill <= 0; hist unchanged.
  - d is ignored that cycle and q=0.
  - cfg_err <= (cfg_len==0) | (cfg_len>MAX_LEN).
- While cfg_err=1: q stays 0 and hist/fill still update. The next legal load clears cfg_err.
- len=1: fill>=0 is always true, so q = en & (d == pat[0]).
- Reset mid-stream discards partial matches immediately.

Optional Feature:
- Macro: SEQ_DET_MATCH_CNT_EN.
- Defined:
  - match_cnt increments by 1 on every clk edge where q=1, saturating at all-ones.
  - Cleared by reset and by cfg_load.
- Undefined: match_cnt port is absent and no counter logic is built.

Decomposition:
- Package seq_det_pkg holds:
  - Default constants (RST_PAT/RST_LEN/RST_OVLAP values).
  - The length-width function.
  - Helper function len_mask(len), which returns an MAX_LEN-bit mask of len ones.
- Natural sub-module: seq_det_cmp, a combinational masked compare of win vs pat under len, returning a hit.
- Top module holds hist, fill, config registers, the error flag and the optional counter.

Test Plan:
- Reset defaults, en=1, d = 1,0,1,0,1,0 → q=1 on bits 4 and 6 only; cfg_err=0.
- Load pattern 4'b1010, len 4, ovlap=0; send 1,0,1,0,1,0,1,0 → q=1 on bits 4 and 8 only.
- Load 8'b1110_0101, len 8, ovlap=1; send 1,1,1,1,0,0,1,0,1 with en=0 for 2 cycles after bit 5 → single q pulse on bit 9; no pulse during the en gaps.
- Load len 0 → cfg_err=1 and q never asserts on any stream. Then load len 2, pattern 2'b11, send 1,1,1 → cfg_err=0, q on bits 2 and 3.
- Reset defaults, send 1,0,1, pulse reset between clock edges, then send 0 → no q; fill=0 right after reset.
- With SEQ_DET_MATCH_CNT_EN, CNT_W=2, pattern 1 len 1, send five 1s → match_cnt 1,2,3,3,3. Then cfg_load → match_cnt=0.
